// File: rtl/axi_scmi_mailbox_mc.sv
// Multi-channel SCMI shared-memory mailbox: per-channel FREE/BUSY/DONE ownership,
// payload words, and doorbell/completion interrupts behind a single-outstanding request port.
module axi_scmi_mailbox_mc #(
  parameter int NUM_CH        = 4,
  parameter int PAYLOAD_WORDS = 8,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic                  req_src_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic [NUM_CH-1:0]     doorbell_irq_o,
  output logic [NUM_CH-1:0]     completion_irq_o
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic [7:0] OFF_STATUS     = 8'h00;
  localparam logic [7:0] OFF_FLAGS      = 8'h04;
  localparam logic [7:0] OFF_DOORBELL   = 8'h08;
  localparam logic [7:0] OFF_COMPLETION = 8'h0C;
  localparam logic [7:0] OFF_PAYLOAD    = 8'h10;

  ch_state_e         r_state     [NUM_CH];
  ch_state_e         w_state_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_flag;
  logic [NUM_CH-1:0] r_db_irq;
  logic [NUM_CH-1:0] r_cmp_irq;
  logic [31:0]       r_payload   [NUM_CH][PAYLOAD_WORDS];

  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic [31:0]       r_rsp_rdata;

  logic                  w_accept;
  logic [ADDR_WIDTH+11:0] w_addr_ext;
  logic                  w_hi_bits;
  logic [3:0]            w_ch;
  logic [7:0]            w_off;
  logic [5:0]            w_pidx;
  logic                  w_ch_ok;
  logic                  w_is_pl;
  logic                  w_pl_ok;
  ch_state_e             w_cur_state;
  logic                  w_cur_flag;
  logic [31:0]           w_cur_pl;
  logic                  w_set1;
  logic                  w_err;
  logic [31:0]           w_rdata;
  logic                  w_wr_flag;
  logic                  w_wr_pl;
  logic                  w_go_busy;
  logic                  w_go_done;
  logic                  w_go_free;
  logic [NUM_CH-1:0]     w_hit;

  assign req_ready_o      = !r_rsp_valid || rsp_ready_i;
  assign w_accept         = req_valid_i && req_ready_o;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_rdata_o      = r_rsp_rdata;
  assign rsp_error_o      = r_rsp_error;
  assign doorbell_irq_o   = r_db_irq;
  assign completion_irq_o = r_cmp_irq;

  // Zero-extend so the "address above the block" test works for any ADDR_WIDTH.
  assign w_addr_ext = {12'd0, req_addr_i};
  assign w_hi_bits  = |w_addr_ext[ADDR_WIDTH+11:12];
  assign w_ch       = w_addr_ext[11:8];
  assign w_off      = w_addr_ext[7:0];
  assign w_ch_ok    = ({1'b0, w_ch} < 5'(NUM_CH));
  assign w_is_pl    = (w_off >= OFF_PAYLOAD);
  assign w_pidx     = 6'((w_off - OFF_PAYLOAD) >> 2);
  assign w_pl_ok    = w_is_pl && ({1'b0, w_pidx} < 7'(PAYLOAD_WORDS));
  assign w_set1     = req_wdata_i[0] && req_wstrb_i[0];

  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    w_cur_state = ST_FREE;
    w_cur_flag  = 1'b0;
    w_cur_pl    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 4'(i)) begin
        w_cur_state = r_state[i];
        w_cur_flag  = r_flag[i];
        for (int j = 0; j < PAYLOAD_WORDS; j++) begin
          if (w_pidx == 6'(j)) w_cur_pl = r_payload[i][j];
        end
      end
    end
  end

  // Register decode; DOORBELL/COMPLETION writes without bit0 set are accepted as no-ops.
  always_comb begin
    w_err     = 1'b0;
    w_rdata   = '0;
    w_wr_flag = 1'b0;
    w_wr_pl   = 1'b0;
    w_go_busy = 1'b0;
    w_go_done = 1'b0;
    w_go_free = 1'b0;
    if (w_hi_bits || !w_ch_ok || (w_addr_ext[1:0] != 2'b00)) begin
      w_err = 1'b1;
    end else if (w_is_pl) begin
      if (!w_pl_ok)                                                   w_err   = 1'b1;
      else if (!req_write_i)                                          w_rdata = w_cur_pl;
      else if (req_src_i ? (w_cur_state == ST_BUSY)
                         : (w_cur_state != ST_BUSY))                  w_wr_pl = 1'b1;
      else                                                            w_err   = 1'b1;
    end else begin
      case (w_off)
        OFF_STATUS: begin
          if (req_write_i) w_err   = 1'b1;
          else             w_rdata = {30'd0, w_cur_state};
        end
        OFF_FLAGS: begin
          if (req_write_i) w_wr_flag = req_wstrb_i[0];
          else             w_rdata   = {31'd0, w_cur_flag};
        end
        OFF_DOORBELL: begin
          if (req_write_i && w_set1) begin
            if (!req_src_i && (w_cur_state == ST_FREE)) w_go_busy = 1'b1;
            else                                        w_err     = 1'b1;
          end
        end
        OFF_COMPLETION: begin
          if (req_write_i && w_set1) begin
            if (req_src_i && (w_cur_state == ST_BUSY))       w_go_done = 1'b1;
            else if (!req_src_i && (w_cur_state == ST_DONE)) w_go_free = 1'b1;
            else                                             w_err     = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i]       = w_accept && !w_err && (w_ch == 4'(i));
      w_state_nxt[i] = r_state[i];
      if (w_hit[i]) begin
        if (w_go_busy)      w_state_nxt[i] = ST_BUSY;
        else if (w_go_done) w_state_nxt[i] = ST_DONE;
        else if (w_go_free) w_state_nxt[i] = ST_FREE;
      end
    end
  end

  // NOTE: payload lives in flops with async reset so it reads 0 after reset; this rules out RAM mapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flag    <= '0;
      r_db_irq  <= '0;
      r_cmp_irq <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_FREE;
        for (int j = 0; j < PAYLOAD_WORDS; j++) r_payload[i][j] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every channel samples pre-edge state; the later per-bit writes override this default.
      r_db_irq <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_hit[i]) begin
          if (w_wr_flag)               r_flag[i]    <= req_wdata_i[0];
          if (w_go_busy)               r_db_irq[i]  <= r_flag[i];
          if (w_go_done && r_flag[i])  r_cmp_irq[i] <= 1'b1;
          if (w_go_free || (w_wr_flag && !req_wdata_i[0])) r_cmp_irq[i] <= 1'b0;
          if (w_wr_pl) begin
            for (int j = 0; j < PAYLOAD_WORDS; j++) begin
              if (w_pidx == 6'(j)) begin
                for (int b = 0; b < 4; b++) begin
                  if (req_wstrb_i[b]) r_payload[i][j][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_error <= w_err;
      r_rsp_rdata <= w_rdata;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_axi_scmi_mailbox_mc.sv
// Directed bench for axi_scmi_mailbox_mc: expected responses are queued when a request
// is driven and compared when the response appears; IRQ outputs checked against constants.
module tb_axi_scmi_mailbox_mc;

  localparam int NUM_CH = 4;
  localparam int PW     = 8;
  localparam int AW     = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic              req_src_i;
  logic [AW-1:0]     req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [3:0]        req_wstrb_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_error_o;
  logic [NUM_CH-1:0] doorbell_irq_o;
  logic [NUM_CH-1:0] completion_irq_o;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    string       tag;
  } exp_t;

  exp_t              sb_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [NUM_CH-1:0] snap_db;
  logic [NUM_CH-1:0] snap_cmp;

  localparam logic W = 1'b1, R = 1'b0, AG = 1'b0, PL = 1'b1;

  axi_scmi_mailbox_mc #(.NUM_CH(NUM_CH), .PAYLOAD_WORDS(PW), .ADDR_WIDTH(AW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_write_i      (req_write_i),
    .req_src_i        (req_src_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .req_wstrb_i      (req_wstrb_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_error_o      (rsp_error_o),
    .doorbell_irq_o   (doorbell_irq_o),
    .completion_irq_o (completion_irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic src, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_src_i   = src;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = strb;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_src_i   = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_err"}, 32'(rsp_error_o), 32'(e.err));
      check({e.tag, "_rdata"}, rsp_rdata_o, e.rd);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic xfer(input logic wr, input logic src, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int n;
    drive(wr, src, addr, wdata, strb);
    sb_q.push_back('{exp_err, exp_rd, tag});
    n = 0;
    while (!req_ready_o && n < 16) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    idle();
    snap_db  = doorbell_irq_o;
    snap_cmp = completion_irq_o;
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    pop_cmp();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b1;
    idle();
    repeat (2) @(negedge clk_i);
    check("rst_ready",  32'(req_ready_o), 32'd1);
    check("rst_valid",  32'(rsp_valid_o), 32'd0);
    check("rst_rdata",  rsp_rdata_o, 32'd0);
    check("rst_error",  32'(rsp_error_o), 32'd0);
    check("rst_db",     32'(doorbell_irq_o), 32'd0);
    check("rst_cmp",    32'(completion_irq_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Channel 2 full handshake
    xfer(R, AG, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, "st2_free");
    xfer(W, AG, 32'h204, 32'h1, 4'hF, 1'b0, 32'h0, "fl2_wr");
    xfer(R, AG, 32'h204, 32'h0, 4'h0, 1'b0, 32'h1, "fl2_rd");
    xfer(W, AG, 32'h210, 32'hCAFE0001, 4'hF, 1'b0, 32'h0, "pl2_wr");
    xfer(W, AG, 32'h208, 32'h0, 4'hF, 1'b0, 32'h0, "db2_nop0");
    check("db2_nop0_irq", 32'(snap_db), 32'h0);
    xfer(W, AG, 32'h208, 32'h1, 4'hE, 1'b0, 32'h0, "db2_nopstrb");
    check("db2_nopstrb_irq", 32'(snap_db), 32'h0);
    xfer(R, AG, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, "st2_still_free");
    xfer(W, AG, 32'h208, 32'h1, 4'hF, 1'b0, 32'h0, "db2_ring");
    check("db2_pulse", 32'(snap_db), 32'h4);
    check("db2_pulse_end", 32'(doorbell_irq_o), 32'h0);
    xfer(R, AG, 32'h200, 32'h0, 4'h0, 1'b0, 32'h1, "st2_busy");
    xfer(R, PL, 32'h208, 32'h0, 4'h0, 1'b0, 32'h0, "db2_rd0");
    xfer(W, AG, 32'h210, 32'h0, 4'hF, 1'b1, 32'h0, "pl2_busy_agent");
    xfer(W, AG, 32'h208, 32'h1, 4'hF, 1'b1, 32'h0, "db2_busy_agent");
    xfer(R, PL, 32'h210, 32'h0, 4'h0, 1'b0, 32'hCAFE0001, "pl2_keep");
    xfer(W, PL, 32'h214, 32'h12345678, 4'h3, 1'b0, 32'h0, "pl2_plat_strb");
    xfer(R, AG, 32'h214, 32'h0, 4'h0, 1'b0, 32'h00005678, "pl2_strb_rd");
    xfer(W, AG, 32'h20C, 32'h1, 4'hF, 1'b1, 32'h0, "cmp2_agent_busy");
    xfer(W, PL, 32'h20C, 32'h1, 4'hF, 1'b0, 32'h0, "cmp2_plat");
    check("cmp2_irq_set", 32'(snap_cmp), 32'h4);
    xfer(R, AG, 32'h200, 32'h0, 4'h0, 1'b0, 32'h2, "st2_done");
    xfer(W, PL, 32'h214, 32'h0, 4'hF, 1'b1, 32'h0, "pl2_done_plat");
    check("cmp2_irq_held", 32'(completion_irq_o), 32'h4);
    xfer(W, AG, 32'h20C, 32'h1, 4'hF, 1'b0, 32'h0, "cmp2_agent_ack");
    check("cmp2_irq_clr", 32'(snap_cmp), 32'h0);
    xfer(R, AG, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, "st2_free_again");

    // Channel 0 with interrupts disabled
    xfer(W, AG, 32'h008, 32'h1, 4'hF, 1'b0, 32'h0, "db0_noint");
    check("db0_noint_irq", 32'(snap_db), 32'h0);
    xfer(R, PL, 32'h000, 32'h0, 4'h0, 1'b0, 32'h1, "st0_busy");

    // Channels 1 and 3 concurrently
    xfer(W, AG, 32'h104, 32'h1, 4'hF, 1'b0, 32'h0, "fl1_wr");
    xfer(W, AG, 32'h108, 32'h1, 4'hF, 1'b0, 32'h0, "db1_ring");
    check("db1_pulse", 32'(snap_db), 32'h2);
    xfer(W, AG, 32'h304, 32'h1, 4'hF, 1'b0, 32'h0, "fl3_wr");
    xfer(W, AG, 32'h308, 32'h1, 4'hF, 1'b0, 32'h0, "db3_ring");
    check("db3_pulse", 32'(snap_db), 32'h8);
    xfer(W, PL, 32'h10C, 32'h1, 4'hF, 1'b0, 32'h0, "cmp1_plat");
    check("cmp1_irq", 32'(snap_cmp), 32'h2);
    xfer(W, PL, 32'h30C, 32'h1, 4'hF, 1'b0, 32'h0, "cmp3_plat");
    check("cmp13_irq", 32'(snap_cmp), 32'hA);
    xfer(W, PL, 32'h00C, 32'h1, 4'hF, 1'b0, 32'h0, "cmp0_plat_noint");
    check("cmp0_noint_irq", 32'(snap_cmp), 32'hA);
    xfer(R, AG, 32'h000, 32'h0, 4'h0, 1'b0, 32'h2, "st0_done");
    xfer(W, AG, 32'h304, 32'h0, 4'hF, 1'b0, 32'h0, "fl3_clr");
    check("cmp3_irq_masked", 32'(snap_cmp), 32'h2);
    xfer(W, AG, 32'h304, 32'h1, 4'hF, 1'b0, 32'h0, "fl3_set");
    check("cmp3_no_reassert", 32'(snap_cmp), 32'h2);
    xfer(R, PL, 32'h304, 32'h0, 4'h0, 1'b0, 32'h1, "fl3_rd");
    xfer(R, PL, 32'h300, 32'h0, 4'h0, 1'b0, 32'h2, "st3_done");

    // Address errors and boundaries
    xfer(R, AG, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0, "err_ch4");
    xfer(R, AG, 32'h030, 32'h0, 4'h0, 1'b1, 32'h0, "err_pl_oob");
    xfer(R, AG, 32'h02C, 32'h0, 4'h0, 1'b0, 32'h0, "pl_last_ok");
    xfer(R, AG, 32'h202, 32'h0, 4'h0, 1'b1, 32'h0, "err_misalign");
    xfer(W, AG, 32'h200, 32'h1, 4'hF, 1'b1, 32'h0, "err_status_wr");
    xfer(R, AG, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0, "err_hi_addr");

    // Response backpressure: second request must not be accepted
    rsp_ready_i = 1'b0;
    drive(R, AG, 32'h210, 32'h0, 4'h0);
    sb_q.push_back('{1'b0, 32'hCAFE0001, "bp_rd"});
    @(negedge clk_i);
    drive(W, AG, 32'h218, 32'hDEADBEEF, 4'hF);
    check("bp_valid_first", 32'(rsp_valid_o), 32'd1);
    pop_cmp();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("bp_valid_hold", 32'(rsp_valid_o), 32'd1);
      check("bp_rdata_hold", rsp_rdata_o, 32'hCAFE0001);
      check("bp_ready_low", 32'(req_ready_o), 32'd0);
    end
    idle();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_released", 32'(rsp_valid_o), 32'd0);
    xfer(R, AG, 32'h218, 32'h0, 4'h0, 1'b0, 32'h0, "bp_no_second");

    // Reset with ch1 DONE and a response pending
    check("pre_rst_cmp", 32'(completion_irq_o), 32'h2);
    rsp_ready_i = 1'b0;
    drive(R, AG, 32'h100, 32'h0, 4'h0);
    sb_q.push_back('{1'b0, 32'h2, "rst_pend_rd"});
    @(negedge clk_i);
    idle();
    check("rst_pend_valid", 32'(rsp_valid_o), 32'd1);
    pop_cmp();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mrst_ready", 32'(req_ready_o), 32'd1);
    check("mrst_valid", 32'(rsp_valid_o), 32'd0);
    check("mrst_rdata", rsp_rdata_o, 32'd0);
    check("mrst_error", 32'(rsp_error_o), 32'd0);
    check("mrst_db",    32'(doorbell_irq_o), 32'd0);
    check("mrst_cmp",   32'(completion_irq_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    xfer(R, AG, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, "st1_after_rst");
    xfer(R, AG, 32'h104, 32'h0, 4'h0, 1'b0, 32'h0, "fl1_after_rst");
    xfer(R, AG, 32'h210, 32'h0, 4'h0, 1'b0, 32'h0, "pl2_after_rst");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
